sram_window_capture: RTL and testbench
======================================

# sram_window_capture

Parametrised window capture/playback controller between the SDRAM frame-buffer read path and the VGA output. During a capture it reduces each in-window camera pixel to RGB555 and writes it to the external asynchronous SRAM. During playback it replays the stored window from SRAM in place of live video. Pixels outside the window are painted with a fill colour. Window position and size, fill colour and capture mode (single-shot or continuous) are configurable.

## Interface
- H_START, 300: first window column (H_Cont units)
- V_START, 100: first window row
- WIN_W, 350: window width in pixels
- WIN_H, 300: window height in lines; WIN_W*WIN_H ≤ 2^ADDR_W
- CTR_W, 13: H/V counter width
- ADDR_W, 20: SRAM address width
- FILL, 10'd500: 10-bit value driven on all three channels outside the window
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_sdram_data_1  in  16  SDRAM word 1 ({G_hi[14:10], B[9:0]})
- i_sdram_data_2  in  16  SDRAM word 2 ({G_lo[14:10], R[9:0]})
- i_sdram_valid  in  1  current SDRAM pixel is valid
- i_H_Cont, i_V_Cont  in  CTR_W  current VGA pixel coordinate
- i_start  in  1  one-cycle pulse: arm a capture
- i_mode  in  1  sampled on i_start: 0 = single-shot (capture once, then loop playback), 1 = continuous (capture every frame, show live)
- i_stop  in  1  one-cycle pulse: return to IDLE
- i_s_data  in  16  SRAM read data (combinational)
- o_s_data  out  16  SRAM write data {1'b0, R5, G5, B5}
- o_s_wen  out  1  SRAM write enable, active-low (0 = write)
- o_s_addr  out  ADDR_W  SRAM address
- o_display_Red, o_display_Green, o_display_Blue  out  10  pixel to VGA
- o_busy  out  1  state is ARM or CAPTURE
- o_frame_done  out  1  one-cycle pulse at the end of each capture
- o_short  out  1  sticky: last capture wrote fewer than WIN_W*WIN_H pixels

## Operation
- in_win = H_START ≤ H < H_START+WIN_W and V_START ≤ V < V_START+WIN_H.
- wr_pix = in_win & i_sdram_valid.
- Reduction: R5 = d2[9:5], G5 = d1[14:10], B5 = d1[9:5].
- Live colour: R = d2[9:0], G = {d1[14:10], d2[14:10]}, B = d1[9:0].
- States:
  - IDLE: no writes; address 0. i_start → ARM and latch i_mode.
  - ARM: wait for V < V_START (top of frame, outside window), then → CAPTURE with count 0.
  - CAPTURE: on each wr_pix cycle, write at address = count, then count++. End of capture is whichever comes first:
    - count reaches WIN_W*WIN_H − 1 while a write is in progress;
    - V ≥ V_START+WIN_H after the window has been entered.
  - At end of capture: pulse o_frame_done. Set o_short = (written < WIN_W*WIN_H). Go to PLAY if mode 0, or ARM if mode 1. Address → 0.
  - PLAY: o_s_wen = 1. The address points to the next window pixel. It increments on each wr_pix cycle, saturates at WIN_W*WIN_H−1, and resets to 0 whenever V < V_START. i_start → ARM (recapture).
- i_stop in any state → IDLE next cycle; a pending write is not issued.
- If i_stop and i_start fall on the same cycle, i_stop wins.
- Display (combinational):
  - outside window: FILL on all three channels;
  - in window, PLAY: {i_s_data[14:10],5'b0}, {i_s_data[9:5],5'b0}, {i_s_data[4:0],5'b0};
  - in window, any other state: live colour.
- o_short clears on i_start.

## Timing
- Reset values: state IDLE; o_s_wen 1; o_s_addr 0; o_s_data 0; o_busy 0; o_frame_done 0; o_short 0.
- o_s_wen, o_s_addr and o_s_data are registered. A write for the pixel sampled at cycle t appears at cycle t+1, for exactly one cycle per wr_pix.
- Playback read has zero latency: o_s_addr is registered and valid before the pixel cycle, and i_s_data is used in the same cycle.
- o_frame_done is asserted the cycle after the final write (or after window exit).
- i_start during CAPTURE is ignored.
- Asynchronous reset mid-capture aborts immediately; SRAM contents are undefined.

## Test plan
- Reset, then i_start with mode 0, WIN_W=4, WIN_H=2, each pixel = {d1,d2} counter pattern → 8 writes to addresses 0..7 with the correct RGB555 data; o_frame_done pulses once; state PLAY; o_short = 0.
- PLAY with an SRAM model preloaded with 0x7C00 → in-window display R=992, G=0, B=0. Outside the window, all channels = 500. Address walks 0..7 and returns to 0 at the next frame top.
- Mode 1 over 3 frames → 3 o_frame_done pulses; window shows live colour; o_s_wen never low outside the window.
- i_sdram_valid held low for 2 in-window pixels → capture ends at window exit with 6 writes; o_short = 1; a following i_start clears it.
- i_stop mid-CAPTURE → IDLE the next cycle with o_s_wen = 1. Simultaneous i_start and i_stop → stays IDLE.
- i_rst_n asserted mid-capture → all outputs at their reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/sram_window_capture.sv
// Window capture/playback controller. It stores in-window camera pixels as RGB555 in an
// async SRAM, replays them in place of live video, and paints a fill colour outside the window.
module sram_window_capture #(
   parameter int unsigned H_START = 300,
   parameter int unsigned V_START = 100,
   parameter int unsigned WIN_W   = 350,
   parameter int unsigned WIN_H   = 300,
   parameter int unsigned CTR_W   = 13,
   parameter int unsigned ADDR_W  = 20,
   parameter logic [9:0]  FILL    = 10'd500
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [15:0]       i_sdram_data_1,
   input  logic [15:0]       i_sdram_data_2,
   input  logic              i_sdram_valid,
   input  logic [CTR_W-1:0]  i_H_Cont,
   input  logic [CTR_W-1:0]  i_V_Cont,
   input  logic              i_start,
   input  logic              i_mode,
   input  logic              i_stop,
   input  logic [15:0]       i_s_data,
   output logic [15:0]       o_s_data,
   output logic              o_s_wen,
   output logic [ADDR_W-1:0] o_s_addr,
   output logic [9:0]        o_display_Red,
   output logic [9:0]        o_display_Green,
   output logic [9:0]        o_display_Blue,
   output logic              o_busy,
   output logic              o_frame_done,
   output logic              o_short
);

   typedef enum logic [1:0] {IDLE, ARM, CAPTURE, PLAY} state_t;

   localparam int unsigned       TOTAL     = WIN_W * WIN_H;
   localparam int unsigned       CNT_W     = ADDR_W + 1;
   localparam logic [CTR_W-1:0]  H_LO      = CTR_W'(H_START);
   localparam logic [CTR_W-1:0]  H_HI      = CTR_W'(H_START + WIN_W);
   localparam logic [CTR_W-1:0]  V_LO      = CTR_W'(V_START);
   localparam logic [CTR_W-1:0]  V_HI      = CTR_W'(V_START + WIN_H);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0]  CNT_ALL   = CNT_W'(TOTAL);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(TOTAL - 1);

   state_t            state_q, state_d;
   logic              mode_q, mode_d;
   logic              entered_q, entered_d;
   logic              wen_q, wen_d;
   logic              done_q, done_d;
   logic              short_q, short_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       data_q, data_d;
   logic              in_win, wr_pix, above_win, cap_end;
   logic [15:0]       pix555;
   logic              unused;

   assign in_win    = (i_H_Cont >= H_LO) && (i_H_Cont < H_HI) &&
                      (i_V_Cont >= V_LO) && (i_V_Cont < V_HI);
   assign wr_pix    = in_win & i_sdram_valid;
   assign above_win = i_V_Cont < V_LO;
   assign pix555    = {1'b0, i_sdram_data_2[9:5], i_sdram_data_1[14:10], i_sdram_data_1[9:5]};
   assign unused    = ^{i_sdram_data_1[15], i_sdram_data_2[15], i_s_data[15]};

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
      state_d   = state_q;
      mode_d    = mode_q;
      entered_d = entered_q;
      wen_d     = 1'b1;
      done_d    = 1'b0;
      short_d   = short_q;
      count_d   = count_q;
      addr_d    = addr_q;
      data_d    = data_q;
      cap_end   = 1'b0;
      unique case (state_q)
         IDLE: begin
            addr_d = '0;
            if (i_start) begin
               state_d = ARM;
               mode_d  = i_mode;
               short_d = 1'b0;
            end
         end
         ARM: begin
            addr_d    = '0;
            count_d   = '0;
            entered_d = 1'b0;
            if (i_start) begin
               mode_d  = i_mode;
               short_d = 1'b0;
            end
            if (above_win) state_d = CAPTURE;
         end
         CAPTURE: begin
            if (!above_win) entered_d = 1'b1;
            if (wr_pix) begin
               wen_d   = 1'b0;
               addr_d  = count_q[ADDR_W-1:0];
               data_d  = pix555;
               count_d = count_q + CNT_W'(1);
               cap_end = (count_q == CNT_LAST);
            end else if (entered_q && (i_V_Cont >= V_HI)) begin
               cap_end = 1'b1;
               addr_d  = '0;
            end
            if (cap_end) begin
               done_d  = 1'b1;
               short_d = (count_d < CNT_ALL);
               state_d = mode_q ? ARM : PLAY;
            end
         end
         PLAY: begin
            // Address leads the beam: it always names the next window pixel to be shown.
            if (above_win)                              addr_d = '0;
            else if (wr_pix && (addr_q != ADDR_LAST))   addr_d = addr_q + ADDR_W'(1);
            if (i_start) begin
               state_d = ARM;
               mode_d  = i_mode;
               short_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (i_stop) begin
         state_d = IDLE;
         mode_d  = mode_q;
         short_d = short_q;
         data_d  = data_q;
         wen_d   = 1'b1;
         addr_d  = '0;
         done_d  = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register updates together at the edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         mode_q    <= 1'b0;
         entered_q <= 1'b0;
         wen_q     <= 1'b1;
         done_q    <= 1'b0;
         short_q   <= 1'b0;
         count_q   <= '0;
         addr_q    <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         entered_q <= entered_d;
         wen_q     <= wen_d;
         done_q    <= done_d;
         short_q   <= short_d;
         count_q   <= count_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
      end
   end

   assign o_s_wen      = wen_q;
   assign o_s_addr     = addr_q;
   assign o_s_data     = data_q;
   assign o_frame_done = done_q;
   assign o_short      = short_q;
   assign o_busy       = (state_q == ARM) || (state_q == CAPTURE);

   always_comb begin
      o_display_Red   = FILL;
      o_display_Green = FILL;
      o_display_Blue  = FILL;
      if (in_win) begin
         if (state_q == PLAY) begin
            o_display_Red   = {i_s_data[14:10], 5'b0};
            o_display_Green = {i_s_data[9:5], 5'b0};
            o_display_Blue  = {i_s_data[4:0], 5'b0};
         end else begin
            o_display_Red   = i_sdram_data_2[9:0];
            o_display_Green = {i_sdram_data_1[14:10], i_sdram_data_2[14:10]};
            o_display_Blue  = i_sdram_data_1[9:0];
         end
      end
   end

endmodule

// File: tb/tb_sram_window_capture.sv
// Scoreboard bench for sram_window_capture: a frame-level model predicts SRAM writes and
// display pixels, and a negedge monitor compares whatever the DUT presents.
module tb_sram_window_capture;

   localparam int H_START = 3;
   localparam int V_START = 2;
   localparam int WIN_W   = 4;
   localparam int WIN_H   = 2;
   localparam int CTR_W   = 13;
   localparam int ADDR_W  = 4;
   localparam int H_TOT   = 10;
   localparam int V_TOT   = 6;
   localparam int TOTAL   = WIN_W * WIN_H;
   localparam int START_PIX = (V_TOT - 1) * H_TOT;
   localparam logic [9:0] FILL_V = 10'd500;

   typedef struct {
      logic [3:0]  addr;
      logic [15:0] data;
   } wr_t;

   typedef struct {
      logic [9:0] r;
      logic [9:0] g;
      logic [9:0] b;
      bit         chk_addr;
      logic [3:0] addr;
   } disp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [15:0] sd1 = '0, sd2 = '0;
   logic sdram_valid = 1'b0, start = 1'b0, mode = 1'b0, stop = 1'b0;
   logic [CTR_W-1:0] h_cont = '0, v_cont = '0;
   logic [15:0] s_rdata, s_wdata;
   logic s_wen;
   logic [ADDR_W-1:0] s_addr;
   logic [9:0] red, green, blue;
   logic busy, frame_done, short_flag;

   logic [15:0] mem [TOTAL];
   wr_t   wr_q[$];
   disp_t disp_q[$];
   wr_t   w_m;
   disp_t e_m;

   int n_vec = 0, n_err = 0, done_cnt = 0, done_exp = 0;
   bit cap = 0, armed = 0, cont = 0, play = 0, short_exp = 0;
   int cnt = 0, play_idx = 0;
   bit chk_stop_next = 0, chk_start_next = 0;
   int cfg_start_mode, cfg_stop_pix, cfg_rst_pix, cfg_drop0, cfg_drop1, cfg_valid_pct;

   always #5 clk = ~clk;

   assign s_rdata = (s_addr < 4'(TOTAL)) ? mem[s_addr[2:0]] : 16'hDEAD;

   sram_window_capture #(
      .H_START(H_START), .V_START(V_START), .WIN_W(WIN_W), .WIN_H(WIN_H),
      .CTR_W(CTR_W), .ADDR_W(ADDR_W), .FILL(FILL_V)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_sdram_data_1(sd1), .i_sdram_data_2(sd2), .i_sdram_valid(sdram_valid),
      .i_H_Cont(h_cont), .i_V_Cont(v_cont),
      .i_start(start), .i_mode(mode), .i_stop(stop),
      .i_s_data(s_rdata), .o_s_data(s_wdata), .o_s_wen(s_wen), .o_s_addr(s_addr),
      .o_display_Red(red), .o_display_Green(green), .o_display_Blue(blue),
      .o_busy(busy), .o_frame_done(frame_done), .o_short(short_flag)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] rgb555(input logic [15:0] a, input logic [15:0] b);
      return {1'b0, b[9:5], a[14:10], a[9:5]};
   endfunction

   // Monitor: compares the pixel shown and any SRAM write presented this cycle.
   always @(negedge clk) begin
      if (disp_q.size() > 0) begin
         e_m = disp_q.pop_front();
         check("disp_red", 32'(red), 32'(e_m.r));
         check("disp_green", 32'(green), 32'(e_m.g));
         check("disp_blue", 32'(blue), 32'(e_m.b));
         if (e_m.chk_addr) check("play_addr", 32'(s_addr), 32'(e_m.addr));
      end
      if (s_wen === 1'b0) begin
         if (wr_q.size() == 0) begin
            check("unexpected_write_wen", 32'(s_wen), 32'd1);
         end else begin
            w_m = wr_q.pop_front();
            check("wr_addr", 32'(s_addr), 32'(w_m.addr));
            check("wr_data", 32'(s_wdata), 32'(w_m.data));
         end
      end
      if (frame_done === 1'b1) done_cnt++;
   end

   task automatic set_cfg(input int smode, input int stop_pix, input int rst_pix,
                          input int drop0, input int drop1, input int pct);
      cfg_start_mode = smode;
      cfg_stop_pix   = stop_pix;
      cfg_rst_pix    = rst_pix;
      cfg_drop0      = drop0;
      cfg_drop1      = drop1;
      cfg_valid_pct  = pct;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_wen"}, 32'(s_wen), 32'd1);
      check({tag, "_addr"}, 32'(s_addr), 32'd0);
      check({tag, "_data"}, 32'(s_wdata), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(frame_done), 32'd0);
      check({tag, "_short"}, 32'(short_flag), 32'd0);
   endtask

   task automatic run_frame();
      for (int vv = 0; vv < V_TOT; vv++) begin
         for (int hh = 0; hh < H_TOT; hh++) begin
            int pix;
            int widx;
            bit win, valid, do_start, do_stop;
            logic [15:0] x1, x2;
            disp_t e;
            wr_t w;
            @(posedge clk); #1;
            rst_n = 1'b1;
            if (chk_stop_next) begin
               check("after_stop_busy", 32'(busy), 32'd0);
               check("after_stop_wen", 32'(s_wen), 32'd1);
               chk_stop_next = 0;
            end
            if (chk_start_next) begin
               check("after_start_short", 32'(short_flag), 32'd0);
               check("after_start_busy", 32'(busy), 32'd1);
               chk_start_next = 0;
            end
            pix = vv * H_TOT + hh;
            if (pix == 0) begin
               play_idx = 0;
               if (armed) begin
                  cap = 1; cnt = 0; armed = 0;
               end
            end
            if (vv == V_START + WIN_H && hh == 0 && cap) begin
               done_exp++;
               short_exp = (cnt < TOTAL);
               cap = 0;
               if (cont) armed = 1;
               else play = 1;
            end
            win = (hh >= H_START) && (hh < H_START + WIN_W) &&
                  (vv >= V_START) && (vv < V_START + WIN_H);
            widx = win ? (vv - V_START) * WIN_W + (hh - H_START) : -1;
            valid = ($urandom_range(99) < cfg_valid_pct);
            if (win && (widx == cfg_drop0 || widx == cfg_drop1)) valid = 0;
            do_start = (cfg_start_mode >= 0) && (pix == START_PIX);
            do_stop  = (pix == cfg_stop_pix);
            x1 = 16'($urandom);
            x2 = 16'($urandom);
            h_cont = CTR_W'(hh);
            v_cont = CTR_W'(vv);
            sd1 = x1;
            sd2 = x2;
            sdram_valid = valid;
            start = do_start;
            stop  = do_stop;
            mode  = do_start ? cfg_start_mode[0] : 1'($urandom_range(1));

            e.chk_addr = 0;
            e.addr = '0;
            if (!win) begin
               e.r = FILL_V; e.g = FILL_V; e.b = FILL_V;
            end else if (play) begin
               e.r = {mem[play_idx][14:10], 5'b0};
               e.g = {mem[play_idx][9:5], 5'b0};
               e.b = {mem[play_idx][4:0], 5'b0};
               e.chk_addr = 1;
               e.addr = 4'(play_idx);
               if (valid && play_idx < TOTAL - 1) play_idx++;
            end else begin
               e.r = x2[9:0];
               e.g = {x1[14:10], x2[14:10]};
               e.b = x1[9:0];
            end
            disp_q.push_back(e);

            if (do_stop) begin
               cap = 0; armed = 0; cont = 0; play = 0;
               chk_stop_next = 1;
            end else begin
               if (cap && win && valid) begin
                  w.addr = 4'(cnt);
                  w.data = rgb555(x1, x2);
                  wr_q.push_back(w);
                  cnt++;
               end
               if (do_start) begin
                  armed = 1; cont = (cfg_start_mode == 1); play = 0; short_exp = 0;
                  chk_start_next = 1;
               end
            end

            if (pix == cfg_rst_pix) begin
               #2;
               rst_n = 1'b0;
               #1;
               check_reset_values("async_rst");
               wr_q.delete();
               cap = 0; armed = 0; cont = 0; play = 0; short_exp = 0;
            end
         end
      end
      #1;
      check("frame_done_count", 32'(done_cnt), 32'(done_exp));
      check("short_flag", 32'(short_flag), 32'(short_exp));
      check("busy_at_frame_end", 32'(busy), 32'(armed));
      check("writes_drained", 32'(wr_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before the end of the run");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, d1;
      for (int i = 0; i < TOTAL; i++) mem[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");

      set_cfg(0, -1, -1, -1, -1, 100); run_frame();   // idle, arm single-shot
      set_cfg(-1, -1, -1, -1, -1, 100); run_frame();  // full capture
      for (int i = 0; i < TOTAL; i++) mem[i] = 16'h7C00;
      set_cfg(-1, -1, -1, -1, -1, 70); run_frame();   // playback of constant red
      for (int i = 0; i < TOTAL; i++) mem[i] = 16'($urandom);
      set_cfg(1, -1, -1, -1, -1, 70); run_frame();    // playback, arm continuous
      set_cfg(-1, -1, -1, -1, -1, 85); run_frame();
      set_cfg(-1, -1, -1, -1, -1, 85); run_frame();
      set_cfg(-1, START_PIX + 1, -1, -1, -1, 85); run_frame();
      set_cfg(0, -1, -1, -1, -1, 100); run_frame();
      d0 = $urandom_range(TOTAL - 1);
      d1 = (d0 + 1 + $urandom_range(TOTAL - 2)) % TOTAL;
      set_cfg(-1, -1, -1, d0, d1, 100); run_frame();  // short capture
      set_cfg(0, -1, -1, -1, -1, 70); run_frame();    // restart clears short
      set_cfg(-1, V_START * H_TOT + H_START + 3, -1, -1, -1, 100); run_frame();
      set_cfg(0, START_PIX, -1, -1, -1, 100); run_frame();  // start and stop together
      set_cfg(0, -1, -1, -1, -1, 100); run_frame();
      set_cfg(-1, -1, (V_START + 1) * H_TOT + H_START + 1, -1, -1, 100); run_frame();
      set_cfg(-1, -1, -1, -1, -1, 100); run_frame();

      @(negedge clk); #1;
      check("display_queue_drained", 32'(disp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
